// File: rtl/burst_mem_if.sv
// rtl/burst_mem_if.sv - request/response bundle between a burst memory master and burst_mem
interface burst_mem_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
);
    logic                    en;
    logic                    wren;
    logic [ADDRESS_SIZE-1:0] addr;
    logic [1:0]              acc_size;
    logic [DATA_SIZE-1:0]    d_in;
    logic [DATA_SIZE-1:0]    d_out;
    logic                    rd_valid;
    logic                    busy;
    logic                    err;

    modport master (
        output en, wren, addr, acc_size, d_in,
        input  d_out, rd_valid, busy, err
    );

    modport slave (
        input  en, wren, addr, acc_size, d_in,
        output d_out, rd_valid, busy, err
    );
endinterface

// File: rtl/burst_mem.sv
// rtl/burst_mem.sv - big-endian byte memory with 1/4/8/16-word bursts; BURST_MEM_RANGE_CHECK_EN enables out-of-range flagging
module burst_mem #(
    parameter int                      ADDRESS_SIZE  = 32,
    parameter int                      DATA_SIZE     = 32,
    parameter int                      MEM_SIZE      = 1048576,
    parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h80020000
) (
    input  logic           clk,
    input  logic           rst,
    burst_mem_if.slave     bus
);
    // Offsets carry one extra bit so base + 4k never silently overflows.
    localparam int             IW        = ADDRESS_SIZE + 1;
    localparam int             MW        = $clog2(MEM_SIZE);
    localparam logic [IW-1:0]  MEM_LIMIT = IW'(MEM_SIZE);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       base_q;
    logic [3:0]          cnt_q;
    logic [3:0]          last_q;
    logic                wr_q;

    logic [IW-1:0]       req_off;
    logic [3:0]          req_last;
    logic                beat_go;
    logic                beat_wr;
    logic [IW-1:0]       beat_off;
    logic [MW-1:0]       beat_idx;
    logic                beat_oob;
    logic [DATA_SIZE-1:0] rd_word;

    logic [7:0]          mem [MEM_SIZE];
    logic [DATA_SIZE-1:0] d_out_q;
    logic                rd_valid_q;

`ifdef BURST_MEM_RANGE_CHECK_EN
    logic                below_q;
    logic                req_below;
    logic                beat_below;
    logic                err_q;
`endif

    // Word-aligned local offset of the incoming request and its last beat number.
    assign req_off = {1'b0, bus.addr - START_ADDRESS} & ~IW'(3);
    always_comb begin
        req_last = 4'd0;
        case (bus.acc_size)
            2'b00:   req_last = 4'd0;
            2'b01:   req_last = 4'd3;
            2'b10:   req_last = 4'd7;
            default: req_last = 4'd15;
        endcase
    end
`ifdef BURST_MEM_RANGE_CHECK_EN
    assign req_below = bus.addr < START_ADDRESS;
`endif

    // State register; reset wins over any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a multi-beat request leaves IDLE, the final beat returns to it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en && (req_last != 4'd0)) state_d = BURST;
            BURST:   if (cnt_q == last_q)              state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs of the FSM: which beat executes this edge, and where.
    always_comb begin
        beat_go  = 1'b0;
        beat_wr  = 1'b0;
        beat_off = '0;
`ifdef BURST_MEM_RANGE_CHECK_EN
        beat_below = 1'b0;
`endif
        if (state_q == IDLE) begin
            beat_go  = bus.en;
            beat_wr  = bus.wren;
            beat_off = req_off;
`ifdef BURST_MEM_RANGE_CHECK_EN
            beat_below = req_below;
`endif
        end else begin
            beat_go  = 1'b1;
            beat_wr  = wr_q;
            beat_off = base_q + IW'({cnt_q, 2'b00});
`ifdef BURST_MEM_RANGE_CHECK_EN
            beat_below = below_q;
`endif
        end
    end

    assign bus.busy = (state_q == BURST);

`ifdef BURST_MEM_RANGE_CHECK_EN
    assign beat_oob = beat_below | (beat_off >= MEM_LIMIT);
    assign beat_idx = beat_off[MW-1:0];
`else
    assign beat_oob = 1'b0;
    assign beat_idx = MW'(beat_off % MEM_LIMIT);
`endif

    // Capture the burst context at acceptance and step the beat counter in BURST.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            cnt_q  <= '0;
            last_q <= '0;
            wr_q   <= 1'b0;
`ifdef BURST_MEM_RANGE_CHECK_EN
            below_q <= 1'b0;
`endif
        end else if (state_q == IDLE) begin
            if (bus.en) begin
                base_q <= req_off;
                cnt_q  <= 4'd1;
                last_q <= req_last;
                wr_q   <= bus.wren;
`ifdef BURST_MEM_RANGE_CHECK_EN
                below_q <= req_below;
`endif
            end
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Byte storage, most significant byte at the lowest index; never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && beat_go && beat_wr && !beat_oob) begin
            mem[beat_idx]          <= bus.d_in[31:24];
            mem[beat_idx + MW'(1)] <= bus.d_in[23:16];
            mem[beat_idx + MW'(2)] <= bus.d_in[15:8];
            mem[beat_idx + MW'(3)] <= bus.d_in[7:0];
        end
    end

    assign rd_word = {mem[beat_idx], mem[beat_idx + MW'(1)],
                      mem[beat_idx + MW'(2)], mem[beat_idx + MW'(3)]};

    // Registered read data with a one-cycle valid strobe per read beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= beat_go & ~beat_wr;
            if (beat_go && !beat_wr) begin
                d_out_q <= beat_oob ? '0 : rd_word;
            end
        end
    end

    assign bus.d_out    = d_out_q;
    assign bus.rd_valid = rd_valid_q;

`ifdef BURST_MEM_RANGE_CHECK_EN
    // One-cycle error pulse after any beat that fell outside the memory window.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= beat_go & beat_oob;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_burst_mem.sv
// tb/tb_burst_mem.sv - scoreboard bench for burst_mem with a byte-array reference model
module tb_burst_mem;
    localparam int          MEM_SIZE = 1024;
    localparam logic [31:0] START    = 32'h80020000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    logic mon_on = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int err_exp = 0;
    int err_seen = 0;

    logic [7:0]  mmem [MEM_SIZE];
    logic [31:0] exp_q [$];
    logic [31:0] wbuf [16];
    logic [31:0] last_dout = 32'h0;

    burst_mem_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) bus ();

    burst_mem #(
        .ADDRESS_SIZE (32),
        .DATA_SIZE    (32),
        .MEM_SIZE     (MEM_SIZE),
        .START_ADDRESS(START)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int beats(input logic [1:0] acc);
        case (acc)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    // Reference behaviour of one beat: local index = aligned (addr - START) + 4k.
    function automatic void model_beat(input bit wr, input logic [31:0] a, input int k,
                                       input logic [31:0] wd);
        logic [31:0] rel;
        longint      idx;
        bit          oob;
        rel = a - START;
        idx = longint'(rel & 32'hFFFF_FFFC) + 4 * k;
`ifdef BURST_MEM_RANGE_CHECK_EN
        oob = (a < START) || (idx >= MEM_SIZE);
`else
        oob = 1'b0;
        idx = idx % MEM_SIZE;
`endif
        if (oob) err_exp++;
        if (wr) begin
            if (!oob) for (int j = 0; j < 4; j++) mmem[idx + j] = wd[31 - 8 * j -: 8];
        end else begin
            exp_q.push_back(oob ? 32'h0 : {mmem[idx], mmem[idx + 1], mmem[idx + 2], mmem[idx + 3]});
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the last beat.
    task automatic do_burst(input bit wr, input logic [31:0] a, input logic [1:0] acc, input bit hold);
        int n;
        int bcnt;
        n = beats(acc);
        bcnt = 0;
        bus.en = 1'b1; bus.wren = wr; bus.addr = a; bus.acc_size = acc; bus.d_in = wbuf[0];
        model_beat(wr, a, 0, wbuf[0]);
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) bcnt++;
            bus.en = hold;
            bus.wren = 1'($urandom_range(0, 1));
            bus.addr = $urandom;
            bus.acc_size = 2'($urandom_range(0, 3));
            bus.d_in = wbuf[k];
            model_beat(wr, a, k, wbuf[k]);
        end
        @(negedge clk);
        check("busy_cycles", 32'(bcnt), 32'(n - 1));
        check("busy_after_burst", 32'(bus.busy), 32'h0);
        if (!hold) bus.en = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every read beat, checks hold and reset values otherwise.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.err === 1'b1) err_seen++;
            if (rst_q) begin
                check("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
                check("reset_d_out", bus.d_out, 32'h0);
                check("reset_err", 32'(bus.err), 32'h0);
                check("reset_busy", 32'(bus.busy), 32'h0);
                last_dout = 32'h0;
            end else if (bus.rd_valid === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rd_valid: got d_out %h, expected no read beat", bus.d_out);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (bus.d_out !== e) begin
                        n_fail++;
                        $display("FAIL read_data: got %h, expected %h", bus.d_out, e);
                    end
                    last_dout = e;
                end
            end else begin
                check("d_out_hold", bus.d_out, last_dout);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mmem[i] = 8'h00;
        bus.en = 1'b0; bus.wren = 1'b0; bus.addr = '0; bus.acc_size = 2'b00; bus.d_in = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;
        rst = 1'b0;

        // Single-word write then read.
        wbuf[0] = 32'hDEADBEEF;
        do_burst(1'b1, START + 32'h10, 2'b00, 1'b0);
        idle(1);
        do_burst(1'b0, START + 32'h10, 2'b00, 1'b0);
        idle(2);

        // Four-beat write and read-back.
        for (int k = 0; k < 4; k++) wbuf[k] = 32'h11111111 * (k + 1);
        do_burst(1'b1, START + 32'h100, 2'b01, 1'b0);
        do_burst(1'b0, START + 32'h100, 2'b01, 1'b0);
        idle(2);

        // Byte order in storage.
        wbuf[0] = 32'hA1B2C3D4;
        do_burst(1'b1, START + 32'h23, 2'b00, 1'b0);
        idle(1);
        check("byte_0x20", 32'(dut.mem[32'h20]), 32'hA1);
        check("byte_0x21", 32'(dut.mem[32'h21]), 32'hB2);
        check("byte_0x23", 32'(dut.mem[32'h23]), 32'hD4);

        // en held high across a 16-beat read, next request chained immediately.
        do_burst(1'b0, START + 32'h100, 2'b11, 1'b1);
        do_burst(1'b0, START + 32'h20, 2'b00, 1'b0);
        idle(2);

        // Reset at beat 3 of an 8-beat write.
        for (int k = 0; k < 8; k++) wbuf[k] = 32'h100 + k;
        bus.en = 1'b1; bus.wren = 1'b1; bus.addr = START + 32'h200; bus.acc_size = 2'b10;
        bus.d_in = wbuf[0];
        model_beat(1'b1, START + 32'h200, 0, wbuf[0]);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            bus.en = 1'b0; bus.d_in = wbuf[k];
            model_beat(1'b1, START + 32'h200, k, wbuf[k]);
        end
        @(negedge clk);
        rst = 1'b1; bus.d_in = wbuf[3];
        @(negedge clk);
        check("busy_after_reset", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        do_burst(1'b0, START + 32'h200, 2'b10, 1'b0);
        idle(2);

        // Burst running off the top of the memory window.
        for (int k = 0; k < 4; k++) wbuf[k] = 32'hC0DE0000 + k;
        do_burst(1'b1, START + MEM_SIZE - 8, 2'b01, 1'b0);
        idle(1);
        do_burst(1'b0, START + MEM_SIZE - 8, 2'b01, 1'b0);
        do_burst(1'b0, START, 2'b01, 1'b0);
        idle(2);

        // Randomized bursts.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            bit          wr;
            bit          hold;
            logic [1:0]  acc;
            wr  = 1'($urandom_range(0, 1));
            acc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = START - $urandom_range(1, 64);
            else                           a = START + $urandom_range(0, MEM_SIZE - 1);
            for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
            hold = (t != 59) && ($urandom_range(0, 3) == 0);
            do_burst(wr, a, acc, hold);
            if (!hold) idle($urandom_range(0, 2));
        end

        idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        check("err_pulse_count", 32'(err_seen), 32'(err_exp));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
